decode_pipe: RTL

Parametrised decode stage with integrated register file and D/E pipeline register for the 5-stage ARM-subset pipeline. Decodes the D-stage instruction, reads operands with optional W-stage write-through, extends immediates to DATA_W and registers everything into the E stage. Also detects load-use hazards and inserts E-stage bubbles, so the top-level hazard unit only handles forwarding and branch flushes.

---
 rtl/decode_pkg.sv | 70 +++++++
 rtl/decode_ctrl.sv | 75 +++++++
 rtl/decode_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared encodings and the decoded control bundle for decode_pipe.
// Build option: DECODE_WRITE_BYPASS_EN (handled in decode_pipe.sv).
package decode_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_NOP = 2'b11
    } op_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_NZCV = 2'b11;

    // reg_src bit positions: bit 0 steers RA1 to the PC, bit 1 steers RA2 to Rd
    localparam int REGSRC_RA1_PC = 0;
    localparam int REGSRC_RA2_RD = 1;

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [1:0] flag_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // True for the data-processing commands this pipeline implements
    function automatic logic is_dp_cmd(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
               (cmd == CMD_CMP) || (cmd == CMD_ORR) || (cmd == CMD_MOV);
    endfunction

    // ALU operation for a data-processing command
    function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
        logic [2:0] alu;
        case (cmd)
            CMD_AND: alu = ALU_AND;
            CMD_SUB: alu = ALU_SUB;
            CMD_CMP: alu = ALU_SUB;
            CMD_ORR: alu = ALU_ORR;
            CMD_MOV: alu = ALU_PASSB;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational main decoder: Op/Funct/Rd to control bundle, immediate
// format, register-source steering and RA2 usage for hazard detection.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int PC_IDX = 15
) (
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output ctrl_t      ctrl,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       ra2_used
);

    localparam logic [3:0] PC_A = 4'(PC_IDX);

    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       u_bit;

    // funct = Instr[25:20]: I, cmd[3:0] (or P/U/B/W for memory), S (or L)
    assign i_bit = funct[5];
    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign u_bit = funct[3];

    // Decode by instruction class; unknown DP commands and Op=11 stay all-zero
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        imm_src  = IMM_8;
        reg_src  = '0;
        ra2_used = 1'b0;
        case (op_t'(op))
            OP_DP: begin
                if (is_dp_cmd(cmd)) begin
                    ctrl.reg_write   = (cmd != CMD_CMP);
                    ctrl.alu_src     = i_bit;
                    ctrl.alu_control = dp_alu(cmd);
                    ra2_used         = ~i_bit;
                    if (cmd == CMD_CMP) begin
                        ctrl.flag_write = FW_NZCV;
                    end else if (s_bit) begin
                        ctrl.flag_write = ((cmd == CMD_ADD) || (cmd == CMD_SUB)) ? FW_NZCV : FW_NZ;
                    end
                end
            end
            OP_MEM: begin
                imm_src          = IMM_12;
                ctrl.alu_src     = ~i_bit;
                ctrl.alu_control = u_bit ? ALU_ADD : ALU_SUB;
                if (s_bit) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end else begin
                    ctrl.mem_write         = 1'b1;
                    reg_src[REGSRC_RA2_RD] = 1'b1;
                    ra2_used               = 1'b1;
                end
            end
            OP_BR: begin
                imm_src                = IMM_24;
                ctrl.branch            = 1'b1;
                ctrl.alu_src           = 1'b1;
                reg_src[REGSRC_RA1_PC] = 1'b1;
            end
            default: begin
            end
        endcase
        ctrl.pc_src = ctrl.branch | (ctrl.reg_write & (rd == PC_A));
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: register file, immediate extender, load-use detection and
// the D/E pipeline register.
// Build option: DECODE_WRITE_BYPASS_EN -- when defined, a W-stage write is
// visible to a D-stage read of the same register in the same cycle.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int PC_IDX = NREG - 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_Instruction_D,
    input  logic              i_Valid_D,
    input  logic [DATA_W-1:0] i_PCPlus8_D,
    input  logic              i_Stall_D,
    input  logic              i_Flush_E,
    input  logic              i_RegWrite_W,
    input  logic [3:0]        i_WA3_W,
    input  logic [DATA_W-1:0] i_Result_W,
    output logic              o_LdStall_D,
    output logic              o_Valid_E,
    output logic [DATA_W-1:0] o_RD1_E,
    output logic [DATA_W-1:0] o_RD2_E,
    output logic [DATA_W-1:0] o_ExtImm_E,
    output logic [3:0]        o_RA1_E,
    output logic [3:0]        o_RA2_E,
    output logic [3:0]        o_WA3_E,
    output logic [3:0]        o_Cond_E,
    output logic              o_PCSrc_E,
    output logic              o_RegWrite_E,
    output logic              o_MemtoReg_E,
    output logic              o_MemWrite_E,
    output logic              o_Branch_E,
    output logic              o_ALUSrc_E,
    output logic [2:0]        o_ALUControl_E,
    output logic [1:0]        o_FlagWrite_E
);

    localparam logic [3:0] PC_A = 4'(PC_IDX);

    logic [31:0]       instr;
    ctrl_t             ctrl_d;
    logic [1:0]        imm_src;
    logic [1:0]        reg_src;
    logic              ra2_used;
    logic [3:0]        ra1_d;
    logic [3:0]        ra2_d;
    logic [3:0]        wa3_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic [DATA_W-1:0] ext_d;
    logic              ld_stall;
    logic              bubble;

    logic [DATA_W-1:0] regs [NREG];

    logic              valid_e;
    ctrl_t             ctrl_e;
    logic [DATA_W-1:0] rd1_e;
    logic [DATA_W-1:0] rd2_e;
    logic [DATA_W-1:0] ext_e;
    logic [3:0]        ra1_e;
    logic [3:0]        ra2_e;
    logic [3:0]        wa3_e;
    logic [3:0]        cond_e;

    assign instr = i_Instruction_D;

    decode_ctrl #(
        .PC_IDX (PC_IDX)
    ) u_ctrl (
        .op       (instr[27:26]),
        .funct    (instr[25:20]),
        .rd       (instr[15:12]),
        .ctrl     (ctrl_d),
        .imm_src  (imm_src),
        .reg_src  (reg_src),
        .ra2_used (ra2_used)
    );

    assign ra1_d = reg_src[REGSRC_RA1_PC] ? PC_A : instr[19:16];
    assign ra2_d = reg_src[REGSRC_RA2_RD] ? instr[15:12] : instr[3:0];
    assign wa3_d = instr[15:12];

    // Register file write; the PC slot is never written so it holds its reset value
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (i_RegWrite_W && (i_WA3_W != PC_A)) begin
            regs[i_WA3_W] <= i_Result_W;
        end
    end

    // Read port 1: PC index overrides both the array and any same-cycle write
    always_comb begin
        rd1_d = regs[ra1_d];
`ifdef DECODE_WRITE_BYPASS_EN
        if (i_RegWrite_W && (i_WA3_W == ra1_d)) begin
            rd1_d = i_Result_W;
        end
`endif
        if (ra1_d == PC_A) begin
            rd1_d = i_PCPlus8_D;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd2_d = regs[ra2_d];
`ifdef DECODE_WRITE_BYPASS_EN
        if (i_RegWrite_W && (i_WA3_W == ra2_d)) begin
            rd2_d = i_Result_W;
        end
`endif
        if (ra2_d == PC_A) begin
            rd2_d = i_PCPlus8_D;
        end
    end

    // Immediate extension: imm8/imm12 zero-extended, imm24 sign-extended word offset
    always_comb begin
        ext_d = '0;
        case (imm_src)
            IMM_12:  ext_d = DATA_W'(instr[11:0]);
            IMM_24:  ext_d = {{(DATA_W-26){instr[23]}}, instr[23:0], 2'b00};
            default: ext_d = DATA_W'(instr[7:0]);
        endcase
    end

    // Load-use: the load in E would not have its data ready for this D read
    always_comb begin
        ld_stall = i_Valid_D & valid_e & ctrl_e.mem_to_reg &
                   ((wa3_e == ra1_d) | ((wa3_e == ra2_d) & ra2_used));
    end

    assign o_LdStall_D = ld_stall;
    assign bubble      = i_Flush_E | ld_stall | i_Stall_D | ~i_Valid_D;

    // D/E register: bubbles zero control and data so a killed slot is inert
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_e <= 1'b0;
            ctrl_e  <= CTRL_BUBBLE;
            rd1_e   <= '0;
            rd2_e   <= '0;
            ext_e   <= '0;
            ra1_e   <= '0;
            ra2_e   <= '0;
            wa3_e   <= '0;
            cond_e  <= '0;
        end else if (bubble) begin
            valid_e <= 1'b0;
            ctrl_e  <= CTRL_BUBBLE;
            rd1_e   <= '0;
            rd2_e   <= '0;
            ext_e   <= '0;
            ra1_e   <= '0;
            ra2_e   <= '0;
            wa3_e   <= '0;
            cond_e  <= '0;
        end else begin
            valid_e <= 1'b1;
            ctrl_e  <= ctrl_d;
            rd1_e   <= rd1_d;
            rd2_e   <= rd2_d;
            ext_e   <= ext_d;
            ra1_e   <= ra1_d;
            ra2_e   <= ra2_d;
            wa3_e   <= wa3_d;
            cond_e  <= instr[31:28];
        end
    end

    assign o_Valid_E      = valid_e;
    assign o_RD1_E        = rd1_e;
    assign o_RD2_E        = rd2_e;
    assign o_ExtImm_E     = ext_e;
    assign o_RA1_E        = ra1_e;
    assign o_RA2_E        = ra2_e;
    assign o_WA3_E        = wa3_e;
    assign o_Cond_E       = cond_e;
    assign o_PCSrc_E      = ctrl_e.pc_src;
    assign o_RegWrite_E   = ctrl_e.reg_write;
    assign o_MemtoReg_E   = ctrl_e.mem_to_reg;
    assign o_MemWrite_E   = ctrl_e.mem_write;
    assign o_Branch_E     = ctrl_e.branch;
    assign o_ALUSrc_E     = ctrl_e.alu_src;
    assign o_ALUControl_E = ctrl_e.alu_control;
    assign o_FlagWrite_E  = ctrl_e.flag_write;

endmodule
